// File: rtl/axi4_types.sv
// Shared AXI4 encodings: response codes, default protection attribute and a
// helper that classifies a response as an error.
package axi4_types;

    localparam logic [1:0] AXI4_RESP_L_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_L_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4_RESP_L_SLVERR = 2'b10;
    localparam logic [1:0] AXI4_RESP_L_DECERR = 2'b11;

    localparam logic [2:0] AXI4_PROT_L_DEFAULT = 3'b000;

    // Anything other than OKAY counts as an error, including EXOKAY.
    function automatic logic axi4_resp_is_err(input logic [1:0] resp);
        return resp != AXI4_RESP_L_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_master_adaptor.sv
// Single-outstanding command/response to AXI4-Lite master bridge.
// Handshakes: a transfer happens on a rising edge where VALID and READY are both high.
module axi4_lite_master_adaptor
    import axi4_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARST,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_write,

    output logic [7:0]          err_count,
    output logic [2:0]          fsm_state,

    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [2:0]          AWPROT,

    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,

    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,

    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [2:0]          ARPROT,

    input  logic                RVALID,
    output logic                RREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              aw_done;
    logic              w_done;

    logic cmd_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic ar_fire;
    logic r_fire;
    logic rsp_fire;
    logic aw_complete;
    logic w_complete;
    logic capture_err;

    assign cmd_ready = (state == IDLE) && !ARST;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign aw_fire  = AWVALID & AWREADY;
    assign w_fire   = WVALID & WREADY;
    assign b_fire   = BVALID & BREADY;
    assign ar_fire  = ARVALID & ARREADY;
    assign r_fire   = RVALID & RREADY;
    assign rsp_fire = rsp_valid & rsp_ready;

    // A channel counts as complete on the very edge its handshake happens.
    assign aw_complete = aw_done | aw_fire;
    assign w_complete  = w_done | w_fire;

    assign capture_err = (b_fire && axi4_resp_is_err(BRESP)) ||
                         (r_fire && axi4_resp_is_err(RRESP));

    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = strb_q;
    assign AWPROT    = AXI4_PROT_L_DEFAULT;
    assign ARPROT    = AXI4_PROT_L_DEFAULT;
    assign fsm_state = state;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_next = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_complete && w_complete) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_fire) begin
                    state_next = RSP;
                end
            end
            RD_REQ: begin
                if (ar_fire) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_fire) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // VALIDs are registered off the current state, so they rise one cycle
    // after the request state is entered and fall on the edge of their own handshake.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            rsp_write <= 1'b0;
            err_count <= '0;
        end else begin
            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                strb_q  <= cmd_strb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_done <= 1'b1;
                end
                if (w_fire) begin
                    w_done <= 1'b1;
                end
            end

            AWVALID   <= (state == WR_REQ) && !aw_complete;
            WVALID    <= (state == WR_REQ) && !w_complete;
            ARVALID   <= (state == RD_REQ) && !ar_fire;
            BREADY    <= (state_next == WR_RESP);
            RREADY    <= (state_next == RD_DATA);
            rsp_valid <= (state_next == RSP);

            if (b_fire) begin
                rsp_rdata <= '0;
                rsp_resp  <= BRESP;
                rsp_write <= 1'b1;
            end else if (r_fire) begin
                rsp_rdata <= RDATA;
                rsp_resp  <= RRESP;
                rsp_write <= 1'b0;
            end

            if (capture_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_adaptor.sv
// Directed and randomized bench for axi4_lite_master_adaptor with an
// in-bench AXI4-Lite slave, response scoreboard and error-count model.
module tb_axi4_lite_master_adaptor;
    import axi4_types::*;

    logic        ACLK;
    logic        ARST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic [7:0]  err_count;
    logic [2:0]  fsm_state;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    int errors = 0;
    int checks = 0;
    int nerr   = 0;
    logic [34:0] exp_q[$];

    axi4_lite_master_adaptor #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .err_count(err_count), .fsm_state(fsm_state),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'($urandom);
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = $urandom;
        RRESP   = 2'($urandom);
    endtask

    // One full transaction. Inputs are driven and outputs sampled on the falling edge.
    // Write: d1 = AW stall, d2 = W stall, d3 = B delay. Read: d1 = AR stall, d2 = R delay.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int d1, input int d2, input int d3,
                          input logic [1:0] resp, input logic [31:0] rdata,
                          input int hold, input logic poke);
        int cyc, c1, c2, wait3, hs, hi1, hi2, exp_lat, err_exp;
        logic done1, done2, got;
        logic [34:0] exp_rsp;

        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_strb  = strb;
        exp_q.push_back({wr, resp, wr ? 32'h0 : rdata});
        @(negedge ACLK);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);

        cyc = 1; c1 = 0; c2 = 0; wait3 = 0; hs = 0; hi1 = 0; hi2 = 0;
        done1 = 1'b0; done2 = 1'b0; got = 1'b0;
        while (!got && cyc < 300) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                check("prot", {AWPROT, ARPROT}, 0);
                slave_idle();
                if (wr) begin
                    check("read_chan_idle", {ARVALID, RREADY}, 0);
                    if (AWVALID) begin
                        hi1++;
                        check("awaddr", AWADDR, addr);
                    end
                    if (WVALID) begin
                        hi2++;
                        check("wdata_wstrb", {WSTRB, WDATA}, {strb, data});
                    end
                    if (done1) check("awvalid_clear", AWVALID, 0);
                    if (done2) check("wvalid_clear", WVALID, 0);
                    check("bready", BREADY, done1 && done2 && hs == 0);
                    if (done1 && done2 && hs == 0) begin
                        BVALID = (wait3 >= d3);
                        if (BVALID) BRESP = resp;
                        wait3++;
                        if (BVALID && BREADY) hs++;
                    end
                    AWREADY = !done1 && (c1 >= d1);
                    WREADY  = !done2 && (c2 >= d2);
                    if (AWVALID) c1++;
                    if (WVALID) c2++;
                    if (AWVALID && AWREADY) done1 = 1'b1;
                    if (WVALID && WREADY) done2 = 1'b1;
                end else begin
                    check("write_chan_idle", {AWVALID, WVALID, BREADY}, 0);
                    if (ARVALID) begin
                        hi1++;
                        check("araddr", ARADDR, addr);
                    end
                    if (done1) check("arvalid_clear", ARVALID, 0);
                    check("rready", RREADY, done1 && hs == 0);
                    if (done1 && hs == 0) begin
                        RVALID = (wait3 >= d2);
                        if (RVALID) begin
                            RDATA = rdata;
                            RRESP = resp;
                        end
                        wait3++;
                        if (RVALID && RREADY) hs++;
                    end
                    ARREADY = !done1 && (c1 >= d1);
                    if (ARVALID) c1++;
                    if (ARVALID && ARREADY) done1 = 1'b1;
                end
                @(negedge ACLK);
                cyc++;
            end
        end
        slave_idle();

        exp_lat = wr ? 3 + ((d1 > d2) ? d1 : d2) + d3 : 3 + d1 + d2;
        check("rsp_timeout", got, 1);
        check("latency", cyc - 1, exp_lat);
        check("valid_cycles", hi1, d1 + 1);
        if (wr) check("wvalid_cycles", hi2, d2 + 1);
        check("resp_handshakes", hs, 1);

        exp_rsp = exp_q.pop_front();
        if (resp != AXI4_RESP_L_OKAY) nerr++;
        err_exp = (nerr > 255) ? 255 : nerr;
        check("rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, exp_rsp);
        check("err_count", err_count, err_exp);
        check("fsm_state_known", $isunknown(fsm_state), 0);

        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr  = $urandom;
            end
            @(negedge ACLK);
            check("hold_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, exp_rsp});
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_no_issue", {AWVALID, WVALID, ARVALID}, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        check("rsp_consumed", rsp_valid, 0);
        check("ready_again", cmd_ready, 1);
    endtask

    initial begin
        logic        r_wr;
        logic [1:0]  r_resp;
        logic [3:0]  r_strb;
        logic [31:0] r_addr;
        logic [31:0] r_data;

        ARST = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b0;
        slave_idle();

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        check("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
        check("rst_err", err_count, 0);
        check("rst_addr", {AWADDR, WDATA, WSTRB}, 0);
        ARST = 1'b0;
        @(negedge ACLK);
        check("post_rst_ready", cmd_ready, 1);

        // Immediate write
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, AXI4_RESP_L_OKAY, 32'h0, 0, 1'b0);
        // Split write: W completes two cycles before AW
        do_txn(1'b1, 32'h24, 32'h12345678, 4'h3, 2, 0, 1, AXI4_RESP_L_OKAY, 32'h0, 0, 1'b0);
        // Read with delayed ARREADY
        do_txn(1'b0, 32'h4C, 32'h0, 4'h0, 4, 0, 0, AXI4_RESP_L_OKAY, 32'h0000_0003, 0, 1'b0);
        // First error response
        check("err_before", err_count, 0);
        do_txn(1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 0, AXI4_RESP_L_SLVERR, 32'h0BAD, 0, 1'b0);
        check("err_first", err_count, 1);
        // Response backpressure with a competing command
        do_txn(1'b1, 32'h80, 32'hCAFEF00D, 4'h5, 1, 2, 0, AXI4_RESP_L_OKAY, 32'h0, 5, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_resp = 2'($urandom_range(0, 3));
            r_strb = 4'($urandom);
            r_addr = $urandom;
            r_data = $urandom;
            do_txn(r_wr, r_addr, r_data, r_strb, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), r_resp, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Saturation
        for (int n = 0; n < 300; n++) begin
            do_txn(1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 0, AXI4_RESP_L_SLVERR, $urandom, 0, 1'b0);
        end
        check("err_saturated", err_count, 255);

        // Reset in the middle of a write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h55AA55AA; cmd_strb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        check("mid_awvalid_up", AWVALID, 1);
        ARST = 1'b1;
        @(negedge ACLK);
        nerr = 0;
        check("mid_valids_drop", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        check("mid_err_clear", err_count, 0);
        ARST = 1'b0;
        @(negedge ACLK);
        check("mid_ready_after", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("mid_no_rsp", {rsp_valid, AWVALID, WVALID}, 0);
        end

        // Fresh transaction after the abandoned one
        do_txn(1'b0, 32'h44, 32'h0, 4'h0, 1, 1, 0, AXI4_RESP_L_DECERR, 32'h77, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
